// File: rtl/game_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_uart_pkg
//  Description : Shared definitions for the game UART frame link. The remote
//                transmitter and the local receiver both use these values.
//                Frame: 0xA5, P0..P6, CHK (CHK = XOR of P0..P6).
//  Contents    : header byte, payload length, P4/P6 field offsets and the
//                receiver FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_uart_pkg;

    localparam logic [7:0] c_HEADER      = 8'hA5;
    localparam int         c_PAYLOAD_LEN = 7;

    // Payload byte positions
    localparam int c_IDX_TX_LO = 0;
    localparam int c_IDX_TY_LO = 1;
    localparam int c_IDX_BX_LO = 2;
    localparam int c_IDX_BY_LO = 3;
    localparam int c_IDX_HI    = 4;
    localparam int c_IDX_HP    = 5;
    localparam int c_IDX_FLAGS = 6;

    // P4 = {tankY[9:8], tankX[9:8], bulletY[9:8], bulletX[9:8]}
    localparam int c_P4_BX_LSB = 0;
    localparam int c_P4_BY_LSB = 2;
    localparam int c_P4_TX_LSB = 4;
    localparam int c_P4_TY_LSB = 6;

    // P6 = {select, hit, tank_dir[1:0], reserved, dir_enemy[2:0]}
    localparam int c_P6_DIR_LSB  = 0;
    localparam int c_P6_TDIR_LSB = 4;
    localparam int c_P6_HIT_BIT  = 6;
    localparam int c_P6_SEL_BIT  = 7;

    // Receiver FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_PAYLOAD = 2'd1;
    localparam state_t c_ST_CHECK   = 2'd2;

    // Joins an 8-bit low part with the 2-bit high part packed in P4.
    function automatic logic [9:0] join10(input logic [7:0] lo,
                                          input logic [7:0] p4,
                                          input int         lsb);
        return {p4[lsb +: 2], lo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : frame_timeout
//  Description : Inter-byte idle counter. Counts cycles without a received
//                byte while a frame is in progress and raises o_timeout once
//                TIMEOUT_CYCLES such cycles have passed. The strobe depends
//                only on the count, so a byte arriving in the timeout cycle
//                can still be handled by the caller after the abort.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_active       - a frame is in progress (counter held at 0 otherwise)
//                i_kick         - byte strobe, restarts the count
//                o_timeout      - combinational timeout strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_kick,
    output logic o_timeout
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    assign o_timeout = i_active && (r_cnt == c_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_active || i_kick || o_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : game_frame_rx
//  Description : Receives 9-byte game state frames (0xA5, P0..P6, CHK) from a
//                UART byte stream and publishes the decoded opponent state.
//                All outputs update together one cycle after the CHK byte,
//                alongside a frame_ok pulse. Rejected frames (bad checksum
//                or inter-byte timeout) pulse frame_err and bump err_cnt.
//  Config      : GAME_FRAME_RX_CHK_EN - when defined, CHK is compared with
//                the XOR of P0..P6; otherwise every complete frame is taken
//                and frame_err reports timeouts only.
//  Ports       : clk, rst (sync, active-high), rx_byte/rx_valid (UART input),
//                decoded positions/HP/directions/flags, frame_ok, frame_err,
//                err_cnt (saturating rejected-frame count).
//  Revision    : 1.0 - initial release
// ============================================================================
module game_frame_rx
    import game_uart_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter logic [7:0] HP_INIT        = 8'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [9:0] Data_X_op,
    output logic [9:0] Data_Y_op,
    output logic [9:0] xpos_bullet_green_fromUART,
    output logic [9:0] ypos_bullet_green_fromUART,
    output logic [7:0] HP_enemy_state_fromUART,
    output logic [2:0] direction_for_enemy_fromUART,
    output logic       tank_our_hit_fromUART,
    output logic       select_mode_from_UART,
    output logic [1:0] direction_tank_fromUART,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    state_t     r_state;
    state_t     w_state_cur;
    state_t     w_state_nxt;
    logic [2:0] r_idx;
    logic [7:0] r_pay [c_PAYLOAD_LEN];
    logic       w_timeout;
    logic       w_store;
    logic       w_frame_done;
    logic       w_chk_ok;
    logic       w_accept;
    logic       w_reject;
    logic       w_unused_p6_rsvd;

    logic [9:0] r_x, r_y, r_bx, r_by;
    logic [7:0] r_hp;
    logic [2:0] r_dir;
    logic       r_hit, r_sel;
    logic [1:0] r_tdir;
    logic       r_ok, r_err;
    logic [7:0] r_err_cnt;

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_active (r_state != c_ST_IDLE),
        .i_kick   (rx_valid),
        .o_timeout(w_timeout)
    );

    // A timeout aborts to IDLE first; any byte in that same cycle is then
    // interpreted from IDLE so a fresh header is not lost.
    assign w_state_cur = w_timeout ? c_ST_IDLE : r_state;

    always_comb begin
        w_state_nxt  = w_state_cur;
        w_store      = 1'b0;
        w_frame_done = 1'b0;
        if (rx_valid) begin
            case (w_state_cur)
                c_ST_IDLE: begin
                    if (rx_byte == c_HEADER) begin
                        w_state_nxt = c_ST_PAYLOAD;
                    end
                end
                c_ST_PAYLOAD: begin
                    // 0xA5 here is plain data; no resynchronisation.
                    w_store = 1'b1;
                    if (r_idx == 3'(c_PAYLOAD_LEN - 1)) begin
                        w_state_nxt = c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = c_ST_IDLE;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef GAME_FRAME_RX_CHK_EN
    // Running XOR of payload bytes, ready when CHK arrives.
    logic [7:0] r_chk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk <= '0;
        end else if (w_state_cur == c_ST_IDLE) begin
            r_chk <= '0;
        end else if (w_store) begin
            r_chk <= r_chk ^ rx_byte;
        end
    end

    assign w_chk_ok = (rx_byte == r_chk);
`else
    assign w_chk_ok = 1'b1;
`endif

    assign w_accept         = w_frame_done && w_chk_ok;
    assign w_reject         = (w_frame_done && !w_chk_ok) || w_timeout;
    assign w_unused_p6_rsvd = r_pay[c_IDX_FLAGS][3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            for (int i = 0; i < c_PAYLOAD_LEN; i++) begin
                r_pay[i] <= '0;
            end
        end else begin
            if (w_state_cur == c_ST_IDLE) begin
                r_idx <= '0;
            end else if (w_store) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_store) begin
                r_pay[r_idx] <= rx_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_bx      <= '0;
            r_by      <= '0;
            r_hp      <= HP_INIT;
            r_dir     <= '0;
            r_hit     <= 1'b0;
            r_sel     <= 1'b0;
            r_tdir    <= '0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_ok  <= w_accept;
            r_err <= w_reject;
            if (w_reject && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_accept) begin
                r_x    <= join10(r_pay[c_IDX_TX_LO], r_pay[c_IDX_HI], c_P4_TX_LSB);
                r_y    <= join10(r_pay[c_IDX_TY_LO], r_pay[c_IDX_HI], c_P4_TY_LSB);
                r_bx   <= join10(r_pay[c_IDX_BX_LO], r_pay[c_IDX_HI], c_P4_BX_LSB);
                r_by   <= join10(r_pay[c_IDX_BY_LO], r_pay[c_IDX_HI], c_P4_BY_LSB);
                r_hp   <= r_pay[c_IDX_HP];
                r_sel  <= r_pay[c_IDX_FLAGS][c_P6_SEL_BIT];
                r_hit  <= r_pay[c_IDX_FLAGS][c_P6_HIT_BIT];
                r_tdir <= r_pay[c_IDX_FLAGS][c_P6_TDIR_LSB +: 2];
                r_dir  <= r_pay[c_IDX_FLAGS][c_P6_DIR_LSB +: 3];
            end
        end
    end

    assign Data_X_op                    = r_x;
    assign Data_Y_op                    = r_y;
    assign xpos_bullet_green_fromUART   = r_bx;
    assign ypos_bullet_green_fromUART   = r_by;
    assign HP_enemy_state_fromUART      = r_hp;
    assign direction_for_enemy_fromUART = r_dir;
    assign tank_our_hit_fromUART        = r_hit;
    assign select_mode_from_UART        = r_sel;
    assign direction_tank_fromUART      = r_tdir;
    assign frame_ok                     = r_ok;
    assign frame_err                    = r_err;
    assign err_cnt                      = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_game_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_frame_rx
//  Description : Self-checking bench for game_frame_rx. A frame-level model
//                (byte queue + idle-gap count) predicts every output each
//                cycle; directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_frame_rx;

    localparam int         c_TO      = 16;
    localparam logic [7:0] c_HP_INIT = 8'd100;
`ifdef GAME_FRAME_RX_CHK_EN
    localparam int c_BAD_ERR = 1;
`else
    localparam int c_BAD_ERR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [9:0] x_o, y_o, bx_o, by_o;
    logic [7:0] hp_o, ecnt_o;
    logic [2:0] dir_o;
    logic       hit_o, sel_o, ok_o, err_o;
    logic [1:0] tdir_o;

    game_frame_rx #(.TIMEOUT_CYCLES(c_TO), .HP_INIT(c_HP_INIT)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .rx_byte                     (rx_byte),
        .rx_valid                    (rx_valid),
        .Data_X_op                   (x_o),
        .Data_Y_op                   (y_o),
        .xpos_bullet_green_fromUART  (bx_o),
        .ypos_bullet_green_fromUART  (by_o),
        .HP_enemy_state_fromUART     (hp_o),
        .direction_for_enemy_fromUART(dir_o),
        .tank_our_hit_fromUART       (hit_o),
        .select_mode_from_UART       (sel_o),
        .direction_tank_fromUART     (tdir_o),
        .frame_ok                    (ok_o),
        .frame_err                   (err_o),
        .err_cnt                     (ecnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_in_frame;
    byte unsigned m_q[$];
    int       m_gap;
    int e_x, e_y, e_bx, e_by, e_hp, e_dir, e_hit, e_sel, e_tdir, e_ok, e_err, e_cnt;

    task automatic m_error();
        e_err = 1;
        if (e_cnt < 255) e_cnt++;
    endtask

    task automatic m_evaluate();
        int x = 0;
        bit good;
        for (int i = 0; i < 7; i++) x = x ^ m_q[i];
`ifdef GAME_FRAME_RX_CHK_EN
        good = (m_q[7] == x);
`else
        good = 1'b1;
`endif
        if (good) begin
            e_x    = m_q[0] + 256 * ((m_q[4] / 16) % 4);
            e_y    = m_q[1] + 256 * (m_q[4] / 64);
            e_bx   = m_q[2] + 256 * (m_q[4] % 4);
            e_by   = m_q[3] + 256 * ((m_q[4] / 4) % 4);
            e_hp   = m_q[5];
            e_sel  = m_q[6] / 128;
            e_hit  = (m_q[6] / 64) % 2;
            e_tdir = (m_q[6] / 16) % 4;
            e_dir  = m_q[6] % 8;
            e_ok   = 1;
        end else begin
            m_error();
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_in_frame = 0; m_q.delete(); m_gap = 0;
            e_x = 0; e_y = 0; e_bx = 0; e_by = 0; e_hp = c_HP_INIT;
            e_dir = 0; e_hit = 0; e_sel = 0; e_tdir = 0;
            e_ok = 0; e_err = 0; e_cnt = 0;
        end else begin
            bit was, tmo;
            e_ok = 0; e_err = 0;
            was = m_in_frame;
            tmo = m_in_frame && (m_gap == c_TO);
            if (tmo) begin
                m_in_frame = 0;
                m_q.delete();
                m_error();
            end
            if (rx_valid) begin
                if (!m_in_frame) begin
                    if (rx_byte == 8'hA5) begin
                        m_in_frame = 1;
                        m_q.delete();
                    end
                end else begin
                    m_q.push_back(rx_byte);
                    if (m_q.size() == 8) begin
                        m_evaluate();
                        m_in_frame = 0;
                    end
                end
            end
            m_gap = (!was || tmo || rx_valid) ? 0 : m_gap + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            check("x",       32'(x_o),    32'(e_x));
            check("y",       32'(y_o),    32'(e_y));
            check("bx",      32'(bx_o),   32'(e_bx));
            check("by",      32'(by_o),   32'(e_by));
            check("hp",      32'(hp_o),   32'(e_hp));
            check("dir",     32'(dir_o),  32'(e_dir));
            check("hit",     32'(hit_o),  32'(e_hit));
            check("sel",     32'(sel_o),  32'(e_sel));
            check("tdir",    32'(tdir_o), 32'(e_tdir));
            check("ok",      32'(ok_o),   32'(e_ok));
            check("err",     32'(err_o),  32'(e_err));
            check("err_cnt", 32'(ecnt_o), 32'(e_cnt));
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] frm [9];

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_byte = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frm(input int gap);
        for (int i = 0; i < 9; i++) send_byte(frm[i], (i == 8) ? 0 : gap);
    endtask

    task automatic load_ref();
        frm[0] = 8'hA5; frm[1] = 8'h55; frm[2] = 8'hC8; frm[3] = 8'h00; frm[4] = 8'h3F;
        frm[5] = 8'h12; frm[6] = 8'h50; frm[7] = 8'hA3; frm[8] = 8'h43;
    endtask

    task automatic check_ref(input string tag);
        check({tag, "_ok"},   32'(ok_o),   1);
        check({tag, "_x"},    32'(x_o),    341);
        check({tag, "_y"},    32'(y_o),    200);
        check({tag, "_bx"},   32'(bx_o),   512);
        check({tag, "_by"},   32'(by_o),   63);
        check({tag, "_hp"},   32'(hp_o),   32'h50);
        check({tag, "_sel"},  32'(sel_o),  1);
        check({tag, "_hit"},  32'(hit_o),  0);
        check({tag, "_tdir"}, 32'(tdir_o), 2);
        check({tag, "_dir"},  32'(dir_o),  3);
    endtask

    initial begin
        int k_err;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;
        // reset state
        check("rst_x",   32'(x_o),    0);
        check("rst_hp",  32'(hp_o),   32'(c_HP_INIT));
        check("rst_ok",  32'(ok_o),   0);
        check("rst_err", 32'(err_o),  0);
        check("rst_cnt", 32'(ecnt_o), 0);

        // valid reference frame
        load_ref();
        send_frm(0);
        check_ref("valid");
        @(posedge clk); #1;
        check("valid_ok_1cyc", 32'(ok_o), 0);

        // corrupted checksum
        frm[8] = 8'h44;
        send_frm(1);
`ifdef GAME_FRAME_RX_CHK_EN
        check("badchk_ok",  32'(ok_o),  0);
        check("badchk_err", 32'(err_o), 1);
        check("badchk_x",   32'(x_o),   341);
        @(posedge clk); #1;
        check("badchk_err_1cyc", 32'(err_o), 0);
`else
        check("badchk_ok",  32'(ok_o),  1);
        check("badchk_err", 32'(err_o), 0);
`endif
        check("badchk_cnt", 32'(ecnt_o), c_BAD_ERR);

        // garbage then valid frame
        load_ref();
        send_byte(8'h00, 0); send_byte(8'hFF, 2); send_byte(8'h12, 0);
        send_frm(0);
        check_ref("garbage");
        check("garbage_cnt", 32'(ecnt_o), c_BAD_ERR);

        // timeout after A5 55 C8
        send_byte(8'hA5, 0); send_byte(8'h55, 0); send_byte(8'hC8, 0);
        k_err = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (err_o && k_err < 0) k_err = k;
        end
        check("timeout_cycle", 32'(k_err), 32'(c_TO + 1));
        check("timeout_cnt", 32'(ecnt_o), c_BAD_ERR + 1);
        send_frm(0);
        check_ref("after_timeout");

        // header lands exactly in the timeout cycle
        send_byte(8'hA5, 0); send_byte(8'h55, 0); send_byte(8'hC8, c_TO);
        send_frm(0);
        check_ref("same_cycle");
        check("same_cycle_cnt", 32'(ecnt_o), c_BAD_ERR + 2);

        // randomized frames
        for (int f = 0; f < 150; f++) begin
            int kind = $urandom_range(0, 9);
            int slow = $urandom_range(0, 7);
            logic [7:0] x = 8'h00;
            if (kind == 0) begin
                for (int g = 0; g < $urandom_range(1, 3); g++) send_byte(8'h00 + 8'($urandom_range(0, 160)), 0);
            end
            frm[0] = 8'hA5;
            for (int i = 1; i < 8; i++) begin
                frm[i] = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom);
                x = x ^ frm[i];
            end
            frm[8] = (kind == 1) ? (x ^ 8'(1 + $urandom_range(0, 254))) : x;
            for (int i = 0; i < 9; i++)
                send_byte(frm[i], (kind == 2 && i == slow) ? (c_TO - 1 + $urandom_range(0, 2))
                                                           : $urandom_range(0, 3));
        end
        repeat (c_TO + 4) begin @(posedge clk); #1; end

        // reset mid-frame
        send_byte(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h77, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_x",   32'(x_o),    0);
        check("midrst_bx",  32'(bx_o),   0);
        check("midrst_hp",  32'(hp_o),   32'(c_HP_INIT));
        check("midrst_err", 32'(err_o),  0);
        check("midrst_cnt", 32'(ecnt_o), 0);
        repeat (c_TO + 4) begin @(posedge clk); #1; end
        check("midrst_noerr", 32'(ecnt_o), 0);
        load_ref();
        send_frm(0);
        check_ref("after_rst");

        // saturation of err_cnt
        for (int n = 0; n < 260; n++) send_byte(8'hA5, c_TO + 1);
        repeat (4) begin @(posedge clk); #1; end
        check("sat_cnt", 32'(ecnt_o), 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
